// File: rtl/comparador_arbitro_if.sv
// Requester-side bus of the shared constant comparator: request/operand in,
// one-hot grant and tagged match result out.
interface comparador_arbitro_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       gnt;
    logic                  result_valid;
    logic                  result;
    logic [IDW-1:0]        result_id;
    logic [15:0]           hit_count;

    modport master (
        output req, data,
        input  gnt, result_valid, result, result_id, hit_count
    );

    modport slave (
        input  req, data,
        output gnt, result_valid, result, result_id, hit_count
    );
endinterface

// File: rtl/comparador_arbitro.sv
// Round-robin share of one (operand == CONST) comparator between NREQ requesters.
// Latency 2 cycles, one grant per 3 cycles; optional match counter under COMPARADOR_ARB_HIT_CNT_EN.
module comparador_arbitro #(
    parameter int CONST = 10,
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    comparador_arbitro_if.slave  bus
);
    localparam logic [WIDTH-1:0] CONST_W  = WIDTH'(CONST);
    localparam logic [IDW-1:0]   LAST_RST = IDW'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

    state_t           state_q;
    logic [IDW-1:0]   last_q;
    logic [IDW-1:0]   win_q;
    logic [WIDTH-1:0] data_q;
    logic [NREQ-1:0]  gnt_q;
    logic             vld_q;
    logic             res_q;
    logic [IDW-1:0]   id_q;

    logic [IDW-1:0]   win_d;
    logic             any_d;

    // Search upward from last+1 with wrap; the first requester found wins.
    always_comb begin
        int idx;
        win_d = last_q;
        any_d = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_d && bus.req[idx]) begin
                win_d = IDW'(idx);
                any_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= LAST_RST;
            win_q   <= '0;
            data_q  <= '0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            res_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    vld_q <= 1'b0;
                    if (any_d) begin
                        win_q   <= win_d;
                        last_q  <= win_d;
                        data_q  <= bus.data[int'(win_d)*WIDTH +: WIDTH];
                        gnt_q   <= NREQ'(1) << win_d;
                        state_q <= CMP;
                    end else begin
                        gnt_q <= '0;
                    end
                end
                CMP: begin
                    gnt_q   <= '0;
                    res_q   <= (data_q == CONST_W);
                    id_q    <= win_q;
                    vld_q   <= 1'b1;
                    state_q <= RESP;
                end
                RESP: begin
                    vld_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    gnt_q   <= '0;
                    vld_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.result_valid = vld_q;
    assign bus.result       = res_q;
    assign bus.result_id    = id_q;

`ifdef COMPARADOR_ARB_HIT_CNT_EN
    logic [15:0] hit_q;

    // Counts on the RESP cycle, when res_q holds the just-compared result.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q <= '0;
        end else if (state_q == RESP && res_q && hit_q != 16'hFFFF) begin
            hit_q <= hit_q + 16'd1;
        end
    end

    assign bus.hit_count = hit_q;
`else
    assign bus.hit_count = '0;
`endif

endmodule

// File: tb/tb_comparador_arbitro.sv
// Bench for comparador_arbitro: directed vectors, corner sequences and random traffic vs a cycle model.
module tb_comparador_arbitro;
    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int CONST = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    comparador_arbitro_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bif ();

    comparador_arbitro #(.CONST(CONST), .WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: transaction timeline of 3 cycles per grant, fair pick by distance from last winner.
    int          m_phase = 0;
    int          m_last  = NREQ - 1;
    int          m_win   = 0;
    int          m_opnd  = 0;
    logic [3:0]  m_gnt   = '0;
    logic        m_vld   = 1'b0;
    logic        m_res   = 1'b0;
    logic [1:0]  m_id    = '0;
    int          m_hits  = 0;
    bit          m_on    = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_last = NREQ - 1; m_gnt = '0; m_vld = 1'b0;
            m_res = 1'b0; m_id = '0; m_hits = 0; m_on = 1'b1;
        end else if (m_phase == 0) begin
            m_vld = 1'b0;
            m_gnt = '0;
            if (bif.req != 0) begin
                for (int d = NREQ; d >= 1; d--)
                    if (bif.req[(m_last + d) % NREQ]) m_win = (m_last + d) % NREQ;
                m_opnd  = int'((bif.data >> (m_win * WIDTH)) & 16'hF);
                m_last  = m_win;
                m_gnt   = 4'(1 << m_win);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_gnt   = '0;
            m_res   = (m_opnd == (CONST % (1 << WIDTH)));
            m_id    = 2'(m_win);
            m_vld   = 1'b1;
            m_phase = 2;
        end else begin
            m_vld   = 1'b0;
            if (m_res && m_hits < 65535) m_hits++;
            m_phase = 0;
        end
    end

    function automatic logic [15:0] exp_hits(input int h);
`ifdef COMPARADOR_ARB_HIT_CNT_EN
        return 16'(h);
`else
        return 16'(h * 0);
`endif
    endfunction

    always @(negedge clk) begin
        if (m_on) begin
            check("model", {bif.gnt, bif.result_valid, bif.result, bif.result_id, bif.hit_count},
                           {m_gnt, m_vld, m_res, m_id, exp_hits(m_hits)});
            check("onehot", 64'($onehot0(bif.gnt)), 64'd1);
        end
    end

    typedef struct packed {
        logic [3:0]  req;
        logic [15:0] data;
        logic [3:0]  gnt;
        logic        res;
        logic [1:0]  id;
    } vec_t;

    vec_t vecs [5];
    int   gidx [$];
    int   gcyc [$];
    int   nmatch;

    initial begin
        vecs[0] = '{req: 4'b0001, data: 16'h000A, gnt: 4'b0001, res: 1'b1, id: 2'd0};
        vecs[1] = '{req: 4'b0100, data: 16'h0900, gnt: 4'b0100, res: 1'b0, id: 2'd2};
        vecs[2] = '{req: 4'b1010, data: 16'hA0A0, gnt: 4'b0010, res: 1'b1, id: 2'd1};
        vecs[3] = '{req: 4'b1000, data: 16'h5000, gnt: 4'b1000, res: 1'b0, id: 2'd3};
        vecs[4] = '{req: 4'b0110, data: 16'h0A30, gnt: 4'b0010, res: 1'b0, id: 2'd1};

        bif.req = '0;
        bif.data = '0;
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("rst_state", {bif.gnt, bif.result_valid, bif.result, bif.result_id, bif.hit_count}, 64'd0);

        for (int i = 0; i < 5; i++) begin
            rst = 1'b1; bif.req = '0; tick();
            rst = 1'b0;
            bif.req = vecs[i].req; bif.data = vecs[i].data;
            tick();
            bif.req = '0; bif.data = 16'hFFFF;
            @(negedge clk);
            check($sformatf("vec%0d_gnt", i), bif.gnt, vecs[i].gnt);
            check($sformatf("vec%0d_vld_early", i), bif.result_valid, 1'b0);
            tick();
            @(negedge clk);
            check($sformatf("vec%0d_vld", i), bif.result_valid, 1'b1);
            check($sformatf("vec%0d_res", i), bif.result, vecs[i].res);
            check($sformatf("vec%0d_id", i), bif.result_id, vecs[i].id);
            tick();
            @(negedge clk);
            check($sformatf("vec%0d_vld_drop", i), bif.result_valid, 1'b0);
            check($sformatf("vec%0d_id_hold", i), bif.result_id, vecs[i].id);
        end

        // Fairness with all requesters held high.
        rst = 1'b1; tick(); rst = 1'b0;
        bif.req = 4'b1111; bif.data = 16'h3A9A;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int b = 0; b < NREQ; b++)
                if (bif.gnt[b]) begin gidx.push_back(b); gcyc.push_back(c); end
        end
        check("fair_count", 64'(gidx.size() >= 6), 64'd1);
        for (int i = 0; i < 6 && i < gidx.size(); i++) begin
            check($sformatf("fair_order%0d", i), 64'(gidx[i]), 64'(i % NREQ));
            if (i > 0) check($sformatf("fair_gap%0d", i), 64'(gcyc[i] - gcyc[i-1]), 64'd3);
        end

        // Rotation: 0 served, then 0 and 2 together -> 2 first.
        bif.req = '0; rst = 1'b1; tick(); rst = 1'b0;
        bif.req = 4'b0001; bif.data = 16'h000A;
        tick();
        bif.req = '0;
        tick();
        bif.req = 4'b0101;
        tick();
        tick();
        @(negedge clk);
        check("rot_gnt2", bif.gnt, 4'b0100);
        bif.req = 4'b0001;
        tick(); tick(); tick();
        @(negedge clk);
        check("rot_gnt0", bif.gnt, 4'b0001);
        bif.req = '0;
        tick(); tick(); tick();

        // Reset during CMP discards the transaction; priority back to 0.
        bif.req = 4'b1111; bif.data = 16'hAAAA;
        tick(); tick(); tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_vld", bif.result_valid, 1'b0);
        check("rst_mid_gnt", bif.gnt, 4'b0000);
        tick();
        @(negedge clk);
        check("rst_first_gnt", bif.gnt, 4'b0001);
        check("rst_no_vld", bif.result_valid, 1'b0);
        bif.req = '0;
        tick(); tick(); tick();

        // Counter: five matches, three mismatches on requester 0.
        rst = 1'b1; tick(); rst = 1'b0;
        nmatch = 0;
        for (int i = 0; i < 8; i++) begin
            bif.req = 4'b0001;
            bif.data = (i == 2 || i == 5 || i == 7) ? 16'(i) : 16'h000A;
            if (!(i == 2 || i == 5 || i == 7)) nmatch++;
            tick();
            bif.req = '0;
            tick(); tick();
        end
        @(negedge clk);
        check("hit_total", bif.hit_count, exp_hits(5));
        check("hit_nmatch", 64'(nmatch), 64'd5);
        rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        check("hit_reset", bif.hit_count, 16'd0);

        // Random traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            tick();
            rst      = ($urandom_range(0, 99) == 0);
            bif.req  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            bif.data = ($urandom_range(0, 1) == 0) ? 16'hAAAA : 16'($urandom);
        end
        rst = 1'b0; bif.req = '0;
        tick(); tick(); tick(); tick();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
